// File: rtl/mult_seq.sv
// Sequential 32x32 unsigned shift-and-add multiplier with a start/busy/done handshake.
// Define MULT_EARLY_DONE_EN to end the iteration as soon as no multiplier bits remain.
module mult_seq (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        busy,
  output logic        done,
  output logic [63:0] product
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t      state;
  logic [63:0] mcand;
  logic [31:0] mplr;
  logic [63:0] acc;
  logic [4:0]  count;

  logic [63:0] acc_next;
  logic [31:0] mplr_shift;
  logic        last_iter;

  // The add for the current iteration feeds both acc and, on the final
  // iteration, product, so the result includes the last partial product.
  always_comb begin
    acc_next   = mplr[0] ? (acc + mcand) : acc;
    mplr_shift = mplr >> 1;
`ifdef MULT_EARLY_DONE_EN
    last_iter  = (mplr_shift == 32'h0) || (count == 5'd31);
`else
    last_iter  = (count == 5'd31);
`endif
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= IDLE;
      busy    <= 1'b0;
      done    <= 1'b0;
      product <= 64'h0;
      mcand   <= 64'h0;
      mplr    <= 32'h0;
      acc     <= 64'h0;
      count   <= 5'd0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            state <= CALC;
            busy  <= 1'b1;
            mcand <= {32'h0, a};
            mplr  <= b;
            acc   <= 64'h0;
            count <= 5'd0;
          end
        end
        CALC: begin
          acc   <= acc_next;
          mcand <= mcand << 1;
          mplr  <= mplr_shift;
          count <= count + 5'd1;
          if (last_iter) begin
            state   <= DONE;
            busy    <= 1'b0;
            done    <= 1'b1;
            product <= acc_next;
          end
        end
        DONE: begin
          // start is deliberately not sampled here; a request must wait for IDLE.
          done  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mult_seq.sv
// Self-checking bench for mult_seq: directed cases with literal expectations plus
// randomized traffic compared every cycle against a cycle-offset behavioural model.
module tb_mult_seq;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [31:0] a;
  logic [31:0] b;
  logic        busy;
  logic        done;
  logic [63:0] product;

  mult_seq dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (start),
    .a       (a),
    .b       (b),
    .busy    (busy),
    .done    (done),
    .product (product)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Cycles from acceptance until done, from the operand alone.
  function automatic int latency_of(input logic [31:0] bv);
`ifdef MULT_EARLY_DONE_EN
    int m;
    m = 0;
    for (int i = 0; i < 32; i++) if (bv[i]) m = i;
    return 2 + m;
`else
    return 33;
`endif
  endfunction

  // Model: offset t counts cycles since the accepting edge (t=1 is the first
  // cycle after it). busy for t<lat, done at t==lat, idle again at t==lat+1.
  int          cyc = 0;
  logic        m_active = 1'b0;
  int          m_t = 0;
  int          m_lat = 0;
  logic [63:0] m_a = 64'h0;
  logic [63:0] m_b = 64'h0;
  logic        exp_busy = 1'b0;
  logic        exp_done = 1'b0;
  logic [63:0] exp_prod = 64'h0;
  logic        chk_en = 1'b0;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (!rst_n) begin
      m_active <= 1'b0;
      exp_busy <= 1'b0;
      exp_done <= 1'b0;
      exp_prod <= 64'h0;
    end else if (m_active) begin
      m_t <= m_t + 1;
      if (m_t + 1 == m_lat) begin
        exp_busy <= 1'b0;
        exp_done <= 1'b1;
        exp_prod <= m_a * m_b;
      end else if (m_t + 1 > m_lat) begin
        m_active <= 1'b0;
        exp_done <= 1'b0;
      end
    end else if (start) begin
      m_active <= 1'b1;
      m_t      <= 1;
      m_a      <= {32'h0, a};
      m_b      <= {32'h0, b};
      m_lat    <= latency_of(b);
      exp_busy <= 1'b1;
      exp_done <= 1'b0;
    end
  end

  // Per-cycle comparison away from the active edge; also counts completions.
  int done_cnt = 0;
  int last_done_cycle = 0;
  always @(negedge clk) begin
    if (chk_en) begin
      check("busy", {63'h0, busy}, {63'h0, exp_busy});
      check("done", {63'h0, done}, {63'h0, exp_done});
      check("product", product, exp_prod);
    end
    if (done === 1'b1) begin
      done_cnt++;
      last_done_cycle = cyc + 1;
      $display("done cycle=%0d product=0x%016h", cyc + 1, product);
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  // Waits for the next done after accepting edge k and checks its latency and value.
  task automatic wait_done(input string name, input int k, input int lat, input logic [63:0] prod);
    int d0;
    logic seen;
    d0 = done_cnt;
    seen = 1'b0;
    for (int i = 0; i < 45 && !seen; i++) begin
      tick();
      if (done_cnt != d0) seen = 1'b1;
    end
    if (!seen) begin
      check({name, "_timeout"}, 64'h0, 64'h1);
    end else begin
      check({name, "_latency"}, 64'(last_done_cycle - k), 64'(lat));
      check({name, "_product"}, product, prod);
      check({name, "_model"}, exp_prod, prod);
    end
  endtask

  task automatic run_op(input string name, input logic [31:0] av, input logic [31:0] bv,
                        input logic [63:0] prod, input int lat);
    int k;
    start = 1'b1;
    a = av;
    b = bv;
    tick();
    k = cyc;
    start = 1'b0;
    a = $urandom;
    b = $urandom;
    wait_done(name, k, lat, prod);
  endtask

`ifdef MULT_EARLY_DONE_EN
  localparam logic [31:0] B30   = 32'h8000_0005;
  localparam logic [63:0] P30   = 64'h0000_0001_8000_000F;
  localparam int          L35   = 4;
  localparam int          L6    = 4;
  localparam int          L1    = 2;
  localparam int          L0    = 2;
  localparam int          L12345 = 15;
`else
  localparam logic [31:0] B30   = 32'h0000_0005;
  localparam logic [63:0] P30   = 64'h0000_0000_0000_000F;
  localparam int          L35   = 33;
  localparam int          L6    = 33;
  localparam int          L1    = 33;
  localparam int          L0    = 33;
  localparam int          L12345 = 33;
`endif

  initial begin
    int k;
    int d0;
    int ops0;
    rst_n = 1'b0;
    start = 1'b1;
    a = 32'h1234_5678;
    b = 32'h9abc_def0;
    tick();
    tick();
    tick();
    start = 1'b0;
    rst_n = 1'b1;
    chk_en = 1'b1;
    check("reset_busy", {63'h0, busy}, 64'h0);
    check("reset_done", {63'h0, done}, 64'h0);
    check("reset_product", product, 64'h0);

    run_op("mul_3x5", 32'd3, 32'd5, 64'h0000_0000_0000_000F, L35);
    run_op("mul_max", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFE_0000_0001, 33);
    run_op("mul_9x1", 32'd9, 32'd1, 64'd9, L1);
    run_op("mul_9xmsb", 32'd9, 32'h8000_0000, 64'h0000_0004_8000_0000, 33);
    run_op("mul_a0", 32'd0, 32'd12345, 64'h0, L12345);
    run_op("mul_b0", 32'd5, 32'd0, 64'h0, L0);

    // Starts during CALC and DONE are dropped; the first IDLE cycle accepts.
    start = 1'b1;
    a = 32'd3;
    b = B30;
    tick();
    k = cyc;
    d0 = done_cnt;
    for (int e = k + 1; e <= k + 34; e++) begin
      start = (e == k + 10) || (e == k + 33) || (e == k + 34);
      a = (e == k + 34) ? 32'd11 : $urandom;
      b = (e == k + 34) ? 32'd13 : $urandom;
      tick();
    end
    start = 1'b0;
    check("ignore_done_count", 64'(done_cnt - d0), 64'd1);
    check("ignore_latency", 64'(last_done_cycle - k), 64'd33);
    check("ignore_product", product, P30);
    wait_done("backtoback", k + 34, 33, 64'd143);

    // Reset mid-CALC aborts with no done pulse.
    start = 1'b1;
    a = 32'd1234;
    b = 32'hF000_1234;
    tick();
    k = cyc;
    start = 1'b0;
    for (int e = k + 1; e < k + 15; e++) tick();
    rst_n = 1'b0;
    start = 1'b1;
    tick();
    rst_n = 1'b1;
    start = 1'b0;
    d0 = done_cnt;
    check("abort_busy", {63'h0, busy}, 64'h0);
    check("abort_product", product, 64'h0);
    for (int i = 0; i < 40; i++) tick();
    check("abort_no_done", 64'(done_cnt - d0), 64'h0);
    run_op("restart_7x6", 32'd7, 32'd6, 64'd42, L6);

    // Random traffic: start, operands and rare resets each cycle.
    ops0 = done_cnt;
    for (int i = 0; i < 60000 && (done_cnt - ops0) < 1000; i++) begin
      start = ($urandom_range(0, 3) != 0);
      a = ($urandom_range(0, 31) == 0) ? 32'h0 : $urandom;
      case ($urandom_range(0, 3))
        0: b = $urandom >> $urandom_range(0, 31);
        1: b = ($urandom_range(0, 7) == 0) ? 32'h0 : 32'hFFFF_FFFF;
        default: b = $urandom;
      endcase
      rst_n = ($urandom_range(0, 299) != 0);
      tick();
    end
    rst_n = 1'b1;
    start = 1'b0;
    check("random_ops_ge_1000", 64'((done_cnt - ops0) >= 1000), 64'h1);
    for (int i = 0; i < 40; i++) tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mult_seq.md
MULT_SEQ -- requirements
Module: mult_seq

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-low reset.
REQ-002 clk  input  1  Rising-edge clock for all state.
REQ-003 rst_n  input  1  Synchronous active-low reset, sampled on rising clk.
REQ-004 start  input  1  Request to begin a multiply; sampled only in IDLE.
REQ-005 a  input  32  Multiplicand, unsigned; sampled in the cycle start is accepted.
REQ-006 b  input  32  Multiplier, unsigned; sampled in the cycle start is accepted.
REQ-007 busy  output  1  High while in CALC.
REQ-008 done  output  1  Single-cycle pulse; product is valid and new.
REQ-009 product  output  64  Unsigned a*b; held until the next completion or reset.

Function
REQ-010 The state machine SHALL have three states: IDLE, CALC and DONE.
REQ-011 IDLE->CALC SHALL occur on the rising edge where start=1; in the same edge mcand <= {32'h0,a}, mplr <= b, acc <= 0, count <= 0.
REQ-012 Each CALC edge SHALL perform: if mplr[0] then acc <= acc + mcand (64-bit, no overflow possible); mcand <= mcand<<1; mplr <= mplr>>1; count <= count+1.
REQ-013 CALC->DONE SHALL occur on the edge that completes the 32nd CALC iteration (count==31 before the edge).
REQ-014 On the CALC->DONE edge, product SHALL be loaded with the final accumulated value, i.e. the value including the last iteration.
REQ-015 DONE SHALL last exactly one cycle with done=1 and busy=0, then transition to IDLE unconditionally.
REQ-016 Latency: with start accepted at edge k, busy SHALL be high for cycles k+1..k+32 and done SHALL be high in cycle k+33.
REQ-017 start asserted in CALC or DONE SHALL be ignored, with no queuing; a, b and product SHALL be unaffected.
REQ-018 Back-to-back operation: start=1 in the first IDLE cycle after DONE SHALL be accepted, giving a minimum issue interval of 34 cycles.
REQ-019 a=0 or b=0 SHALL yield product=0 with normal latency (but see REQ-025).
REQ-020 Changes on a or b after acceptance SHALL NOT affect the result in progress.

Reset
REQ-021 When rst_n=0 at a rising edge, the block SHALL go to IDLE and clear busy, done, product, acc, mcand, mplr and count to 0.
REQ-022 Reset during CALC or DONE SHALL abort the operation: no done pulse, and product reads 0 from the next cycle.
REQ-023 When rst_n=0 and start=1 at the same edge, reset SHALL win and start SHALL be dropped.

Configuration
REQ-024 Macro MULT_EARLY_DONE_EN SHALL select the termination rule for CALC.
REQ-025 With MULT_EARLY_DONE_EN defined, CALC SHALL exit to DONE on the edge where the shifted mplr becomes 0 or count reaches 31, whichever comes first. The minimum is one CALC cycle, so latency is 2 + (bit index of the MSB of b), floored at 2, i.e. b in {0,1} gives done at k+2.
REQ-026 With MULT_EARLY_DONE_EN undefined, CALC SHALL always run 32 iterations per REQ-013/016, independent of operand values.
REQ-027 The product value, the handshake and the reset behaviour SHALL be identical in both configurations; only the latency differs.

Verification
REQ-028 a=3, b=5, start at edge k -> done=1 only in cycle k+33, product=64'h0000_0000_0000_000F; busy high k+1..k+32.
REQ-029 a=b=32'hFFFF_FFFF -> product=64'hFFFF_FFFE_0000_0001 with done after 32 CALC cycles.
REQ-030 start pulsed at k+10 and k+33 during the operation from REQ-028 -> both ignored; a single done at k+33; a new start at k+34 is accepted.
REQ-031 rst_n=0 at k+15 mid-CALC -> busy=0, product=0 and no done pulse thereafter; a restart with a=7, b=6 yields product=42.
REQ-032 With MULT_EARLY_DONE_EN: a=9, b=1 -> done at k+2, product=9; a=9, b=32'h8000_0000 -> done at k+33, product=64'h0000_0004_8000_0000. Without the macro, both give done at k+33.
REQ-033 Random operands (at least 1000 samples) in both configurations SHALL match a 64-bit reference multiply, with the done timing per REQ-016/025.
